// File: rtl/fxp_arb_pkg.sv
// Shared definitions for the fixed-point multiplier arbiter: default operand
// widths, requester count and the transaction FSM state encoding.
package fxp_arb_pkg;

  localparam int DEF_WHOLE_W = 16;
  localparam int DEF_FRAC_W  = 16;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fxp_mul_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first requester
// found when searching upward from ptr+1 (wrapping), plus an any-valid flag.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_valid
);

  logic [IDW-1:0] cand;

  // Walk from the farthest offset to the nearest so the last hit written is
  // the requester closest after ptr.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    grant_idx = '0;
    cand      = '0;
    any_valid = |req;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDW'((int'(ptr) + off) % NUM_REQ);
      if (req[cand]) grant_idx = cand;
    end
  end

endmodule

// File: rtl/fxp_mul_arbiter.sv
// fxp_mul_arbiter: shares one external fixed-point multiplier between
// NUM_REQ requesters. Each transaction runs IDLE -> ISSUE -> WAIT -> RESP.
// Operands and product pass through untouched; no arithmetic is done here.
// Build option: define FXP_ARB_PRIORITY_EN to give requester 0 strict
// priority, with round-robin among the remaining requesters.
module fxp_mul_arbiter
  import fxp_arb_pkg::*;
#(
  parameter int wholeWidth    = DEF_WHOLE_W,
  parameter int fractionWidth = DEF_FRAC_W,
  parameter int NUM_REQ       = DEF_NUM_REQ,
  localparam int W            = wholeWidth + fractionWidth,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic                 mul_en,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [W-1:0]         mul_product,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W-1:0]         rsp_product
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_product_q, rsp_product_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [IDW-1:0]     pick_idx, grant_idx;
  logic               pick_any, any_valid, ptr_upd;
  logic [W-1:0]       a_sel, b_sel;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr_pick (
    .req       (pick_req),
    .ptr       (last_q),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

`ifdef FXP_ARB_PRIORITY_EN
  // Requester 0 wins outright and leaves the rotation pointer alone; the
  // round-robin only ever sees requesters 1..NUM_REQ-1.
  assign pick_req  = {req_valid[NUM_REQ-1:1], 1'b0};
  assign grant_idx = req_valid[0] ? '0 : pick_idx;
  assign any_valid = req_valid[0] | pick_any;
  assign ptr_upd   = ~req_valid[0];
`else
  assign pick_req  = req_valid;
  assign grant_idx = pick_idx;
  assign any_valid = pick_any;
  assign ptr_upd   = 1'b1;
`endif

  // Operand mux for the granted requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  // Transaction FSM and capture of operands, id and product.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    id_d          = id_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = grant_idx;
          if (ptr_upd) last_d = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rsp_product_d = mul_product;
        rsp_id_d      = id_q;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_q        <= IDW'(NUM_REQ - 1);
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      last_q        <= last_d;
      id_q          <= id_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  // Grant is advertised only in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && state_q == IDLE && any_valid) req_ready[grant_idx] = 1'b1;
  end

  assign mul_en      = (state_q == ISSUE);
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

endmodule

// File: tb/tb_fxp_mul_arbiter.sv
// Directed bench for fxp_mul_arbiter with a one-cycle Q16.16 multiplier model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_fxp_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic            mul_en;
  logic [W-1:0]    mul_a, mul_b;
  logic [W-1:0]    mul_product = '0;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_product;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  int          grant_log[$];
  int          grant_cyc[$];
  int          rsp_id_log[$];
  logic [31:0] rsp_prod_log[$];
  int          rsp_cyc[$];

  fxp_mul_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mul_en      (mul_en),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
  );

  always #5 clock = ~clock;

  // Behavioural Q16.16 multiplier, result valid the cycle after mul_en.
  logic [63:0] full_prod;
  assign full_prod = {32'b0, mul_a} * {32'b0, mul_b};
  always @(posedge clock) if (mul_en) mul_product <= full_prod[47:16];

  // Log grants and completed response handshakes with their cycle numbers.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          grant_log.push_back(i);
          grant_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_id_log.push_back(int'(rsp_id));
        rsp_prod_log.push_back(rsp_product);
        rsp_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    rsp_id_log.delete();
    rsp_prod_log.delete();
    rsp_cyc.delete();
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 0);
    check({pfx, "_mul_en"}, mul_en, 0);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_id"}, rsp_id, 0);
    check({pfx, "_rsp_product"}, rsp_product, 0);
    check({pfx, "_mul_a"}, mul_a, 0);
    check({pfx, "_mul_b"}, mul_b, 0);
  endtask

  int exp_order[5];
  logic [31:0] exp_prod[4];
  int n_one;

  initial begin
`ifdef FXP_ARB_PRIORITY_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    exp_prod = '{32'h0002_0000, 32'h0004_0000, 32'h0006_0000, 32'h0008_0000};

    // Reset state, with all requesters asking so the grant gating is seen.
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("rst");
    req_valid = '0;
    reset_n   = 1'b1;

    // Single request from requester 2: 2.0 * 3.0 = 6.0.
    drive_edge();
    set_ops(2, 32'h0002_0000, 32'h0003_0000);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    @(negedge clock);
    check("single_ready", req_ready, 4'b0100);
    drive_edge();
    req_valid = '0;
    @(negedge clock);
    check("single_mul_en", mul_en, 1);
    check("single_mul_a", mul_a, 32'h0002_0000);
    check("single_mul_b", mul_b, 32'h0003_0000);
    check("single_ready_off", req_ready, 0);
    @(negedge clock);
    check("single_mul_en_off", mul_en, 0);
    check("single_mul_a_hold", mul_a, 32'h0002_0000);
    check("single_rsp_early", rsp_valid, 0);
    @(negedge clock);
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 2);
    check("single_rsp_product", rsp_product, 32'h0006_0000);
    @(negedge clock);
    check("single_rsp_clear", rsp_valid, 0);

    // Fresh reset, then all four requesters held valid with rsp_ready high.
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    clear_logs();
    drive_edge();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'((i + 1) << 16), 32'h0002_0000);
    req_valid = 4'b1111;
    repeat (21) @(negedge clock);
    drive_edge();
    req_valid = '0;
    repeat (8) @(negedge clock);
    check("rr_grant_count_ok", grant_log.size() >= 5, 1);
    check("rr_rsp_count_ok", rsp_id_log.size() >= 5, 1);
    if (grant_log.size() >= 5 && rsp_id_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("rr_grant_%0d", k), grant_log[k], exp_order[k]);
        check($sformatf("rr_rsp_id_%0d", k), rsp_id_log[k], exp_order[k]);
        check($sformatf("rr_rsp_prod_%0d", k), rsp_prod_log[k], exp_prod[exp_order[k]]);
      end
      for (int k = 0; k < 4; k++)
        check($sformatf("rr_rsp_gap_%0d", k), rsp_cyc[k+1] - rsp_cyc[k], 4);
      check("rr_latency", rsp_cyc[0] - grant_cyc[0], 3);
    end

    // Response back-pressure: requester 1 (0.5 * 10.0 = 5.0), then
    // requester 3 (3.0 * 3.0 = 9.0) waits while the response is stalled.
    clear_logs();
    drive_edge();
    rsp_ready = 1'b0;
    set_ops(1, 32'h0000_8000, 32'h000A_0000);
    set_ops(3, 32'h0003_0000, 32'h0003_0000);
    req_valid = 4'b0010;
    @(negedge clock);
    check("stall_grant", req_ready, 4'b0010);
    drive_edge();
    req_valid = 4'b1000;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      check($sformatf("stall_valid_%0d", k), rsp_valid, 1);
      check($sformatf("stall_id_%0d", k), rsp_id, 1);
      check($sformatf("stall_prod_%0d", k), rsp_product, 32'h0005_0000);
      check($sformatf("stall_no_ready_%0d", k), req_ready, 0);
    end
    drive_edge();
    rsp_ready = 1'b1;
    @(negedge clock);
    check("stall_hs_valid", rsp_valid, 1);
    check("stall_hs_no_ready", req_ready, 0);
    @(negedge clock);
    check("stall_next_grant", req_ready, 4'b1000);
    drive_edge();
    req_valid = '0;
    repeat (4) @(negedge clock);
    check("stall_rsp_count", rsp_id_log.size(), 2);
    if (rsp_id_log.size() == 2) begin
      check("stall_second_id", rsp_id_log[1], 3);
      check("stall_second_prod", rsp_prod_log[1], 32'h0009_0000);
    end

    // Reset in WAIT: transaction abandoned, next grant goes to requester 0.
    drive_edge();
    set_ops(2, 32'h0005_0000, 32'h0002_0000);
    req_valid = 4'b0100;
    @(negedge clock);
    check("mid_rst_grant", req_ready, 4'b0100);
    drive_edge();
    req_valid = '0;
    repeat (2) @(negedge clock);
    #1;
    req_valid = 4'b1111;
    reset_n   = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(negedge clock);
    req_valid = '0;
    clear_logs();
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("mid_rst_no_rsp", rsp_id_log.size(), 0);
    check("mid_rst_no_valid", rsp_valid, 0);
    drive_edge();
    set_ops(0, 32'h0001_0000, 32'h0007_0000);
    req_valid = 4'b1111;
    @(negedge clock);
    check("mid_rst_first_grant", req_ready, 4'b0001);
    drive_edge();
    req_valid = '0;
    repeat (3) @(negedge clock);
    check("mid_rst_rsp_valid", rsp_valid, 1);
    check("mid_rst_rsp_id", rsp_id, 0);
    check("mid_rst_rsp_prod", rsp_product, 32'h0007_0000);

    // Requester 1 pulses valid while busy and drops it: never granted.
    clear_logs();
    drive_edge();
    set_ops(2, 32'h0004_0000, 32'h0004_0000);
    req_valid = 4'b0100;
    @(negedge clock);
    check("pulse_grant", req_ready, 4'b0100);
    drive_edge();
    req_valid = 4'b0010;
    drive_edge();
    drive_edge();
    req_valid = '0;
    repeat (6) @(negedge clock);
    n_one = 0;
    foreach (grant_log[k]) if (grant_log[k] == 1) n_one++;
    foreach (rsp_id_log[k]) if (rsp_id_log[k] == 1) n_one++;
    check("pulse_req1_seen", n_one, 0);
    check("pulse_grant_count", grant_log.size(), 1);
    check("pulse_rsp_count", rsp_id_log.size(), 1);
    if (rsp_id_log.size() == 1) begin
      check("pulse_rsp_id", rsp_id_log[0], 2);
      check("pulse_rsp_prod", rsp_prod_log[0], 32'h0010_0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
